// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_pkg
//  Brief    : RV32I shared constants, immediate formats and ID/EX record
//  Revision : 1.0  initial release
// ============================================================================
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        IMM_R = 3'd0,
        IMM_I = 3'd1,
        IMM_S = 3'd2,
        IMM_B = 3'd3,
        IMM_U = 3'd4,
        IMM_J = 3'd5
    } imm_fmt_e;

    // Fields captured into the ID/EX register alongside ex_valid
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic        illegal;
    } idex_t;

    // Immediate layout implied by the opcode; unknown opcodes yield no immediate
    function automatic imm_fmt_e imm_fmt_of(input logic [6:0] opcode);
        case (opcode)
            OP_IMM, LOAD, JALR: imm_fmt_of = IMM_I;
            STORE:              imm_fmt_of = IMM_S;
            BRANCH:             imm_fmt_of = IMM_B;
            LUI, AUIPC:         imm_fmt_of = IMM_U;
            JAL:                imm_fmt_of = IMM_J;
            default:            imm_fmt_of = IMM_R;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/decode_stage_if.sv
`default_nettype none
// ============================================================================
//  Module   : decode_stage_if
//  Brief    : Fetch, register-file, writeback-snoop and ID/EX bundle
//  Revision : 1.0  initial release
// ============================================================================
interface decode_stage_if;
    import riscv_pkg::*;

    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [4:0]  readAddr1;
    logic [4:0]  readAddr2;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        wb_writeEnable;
    logic [4:0]  wb_writeAddr;
    logic [31:0] wb_writeData;
    logic        flush;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_pc;
    logic [31:0] ex_rs1_val;
    logic [31:0] ex_rs2_val;
    logic [31:0] ex_imm;
    logic [4:0]  ex_rd;
    logic [6:0]  ex_opcode;
    logic [2:0]  ex_funct3;
    logic [6:0]  ex_funct7;
    logic        ex_illegal;

    // Decode-stage view
    modport slave (
        input  if_valid, if_instr, if_pc, rs1_data, rs2_data,
               wb_writeEnable, wb_writeAddr, wb_writeData, flush, ex_ready,
        output if_ready, readAddr1, readAddr2, ex_valid, ex_pc, ex_rs1_val,
               ex_rs2_val, ex_imm, ex_rd, ex_opcode, ex_funct3, ex_funct7,
               ex_illegal
    );

    // Surrounding pipeline view (fetch, register file, writeback, execute)
    modport master (
        output if_valid, if_instr, if_pc, rs1_data, rs2_data,
               wb_writeEnable, wb_writeAddr, wb_writeData, flush, ex_ready,
        input  if_ready, readAddr1, readAddr2, ex_valid, ex_pc, ex_rs1_val,
               ex_rs2_val, ex_imm, ex_rd, ex_opcode, ex_funct3, ex_funct7,
               ex_illegal
    );

endinterface
`default_nettype wire

// File: rtl/decode_stage_imm_gen.sv
`default_nettype none
// ============================================================================
//  Module   : imm_gen
//  Brief    : Combinational RV32I immediate builder, sign-extended from bit 31
//  Revision : 1.0  initial release
// ============================================================================
module imm_gen
    import riscv_pkg::*;
(
    input  wire logic [31:7] instr,
    input  imm_fmt_e         fmt,
    output logic [31:0]      imm
);

    // Reassemble the scattered immediate bits for the given format
    always_comb begin
        imm = '0;
        case (fmt)
            IMM_I: imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U: imm = {instr[31:12], 12'b0};
            IMM_J: imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
//  Module   : decode_stage
//  Brief    : RV32I decode/operand fetch with writeback bypass, busy
//             scoreboard for RAW/WAW stalls and ID/EX pipeline register
//  Revision : 1.0  initial release
// ============================================================================
module decode_stage
    import riscv_pkg::*;
#(
    parameter int XLEN = riscv_pkg::XLEN,
    parameter int NREG = 32
) (
    input  wire logic     clk,
    input  wire logic     reset,
    decode_stage_if.slave bus
);

    logic [6:0]      w_opcode;
    logic [4:0]      w_rd;
    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic            w_legal;
    logic            w_uses_rs1;
    logic            w_uses_rs2;
    logic            w_rd_class;
    logic            w_writes_rd;
    logic            w_byp1;
    logic            w_byp2;
    logic [XLEN-1:0] w_rs1_val;
    logic [XLEN-1:0] w_rs2_val;
    logic [31:0]     w_imm;
    logic            w_hazard;
    logic            w_if_ready;
    logic            w_accept;
    idex_t           w_idex_next;
    logic [NREG-1:0] w_busy_next;

    logic            r_ex_valid;
    idex_t           r_idex;
    logic [NREG-1:0] r_busy;

    assign w_opcode = bus.if_instr[6:0];
    assign w_rd     = bus.if_instr[11:7];
    assign w_rs1    = bus.if_instr[19:15];
    assign w_rs2    = bus.if_instr[24:20];

    assign bus.readAddr1 = w_rs1;
    assign bus.readAddr2 = w_rs2;

    // Which architectural resources the presented opcode touches
    always_comb begin
        w_legal    = 1'b1;
        w_uses_rs1 = 1'b0;
        w_uses_rs2 = 1'b0;
        w_rd_class = 1'b0;
        case (w_opcode)
            OP:                 begin w_uses_rs1 = 1'b1; w_uses_rs2 = 1'b1; w_rd_class = 1'b1; end
            OP_IMM, LOAD, JALR: begin w_uses_rs1 = 1'b1; w_rd_class = 1'b1; end
            STORE, BRANCH:      begin w_uses_rs1 = 1'b1; w_uses_rs2 = 1'b1; end
            LUI, AUIPC, JAL:    w_rd_class = 1'b1;
            default:            w_legal = 1'b0;
        endcase
    end

    assign w_writes_rd = w_rd_class && (w_rd != 5'd0);

    // A writeback landing this cycle supersedes the stale register-file read
    assign w_byp1    = bus.wb_writeEnable && (bus.wb_writeAddr == w_rs1);
    assign w_byp2    = bus.wb_writeEnable && (bus.wb_writeAddr == w_rs2);
    assign w_rs1_val = (w_rs1 == 5'd0) ? '0 : (w_byp1 ? bus.wb_writeData : bus.rs1_data);
    assign w_rs2_val = (w_rs2 == 5'd0) ? '0 : (w_byp2 ? bus.wb_writeData : bus.rs2_data);

    imm_gen u_imm_gen (
        .instr (bus.if_instr[31:7]),
        .fmt   (imm_fmt_of(w_opcode)),
        .imm   (w_imm)
    );

    // RAW on either source, or WAW on the destination, unless writeback frees it now
    assign w_hazard =
        (w_uses_rs1 && (w_rs1 != 5'd0) && r_busy[w_rs1] && !w_byp1) ||
        (w_uses_rs2 && (w_rs2 != 5'd0) && r_busy[w_rs2] && !w_byp2) ||
        (w_writes_rd && r_busy[w_rd] &&
         !(bus.wb_writeEnable && (bus.wb_writeAddr == w_rd)));

    assign w_if_ready   = !reset && !bus.flush && !w_hazard && (!r_ex_valid || bus.ex_ready);
    assign w_accept     = bus.if_valid && w_if_ready;
    assign bus.if_ready = w_if_ready;

    assign w_idex_next.pc      = bus.if_pc;
    assign w_idex_next.rs1_val = w_rs1_val;
    assign w_idex_next.rs2_val = w_rs2_val;
    assign w_idex_next.imm     = w_imm;
    assign w_idex_next.rd      = w_writes_rd ? w_rd : 5'd0;
    assign w_idex_next.opcode  = w_opcode;
    assign w_idex_next.funct3  = bus.if_instr[14:12];
    assign w_idex_next.funct7  = bus.if_instr[31:25];
    assign w_idex_next.illegal = !w_legal;

    // Scoreboard: writeback and flush release, then an accepted writer claims
    always_comb begin
        w_busy_next = r_busy;
        if (bus.wb_writeEnable)
            w_busy_next[bus.wb_writeAddr] = 1'b0;
        if (bus.flush && r_ex_valid && (r_idex.rd != 5'd0))
            w_busy_next[r_idex.rd] = 1'b0;
        if (w_accept && w_writes_rd)
            w_busy_next[w_rd] = 1'b1;
        w_busy_next[0] = 1'b0;
    end

    // Busy bit register
    always_ff @(posedge clk) begin
        if (reset) r_busy <= '0;
        else       r_busy <= w_busy_next;
    end

    // ID/EX register: load on accept, drop when consumed or flushed, else hold
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ex_valid <= 1'b0;
            r_idex     <= '0;
        end else if (bus.flush) begin
            r_ex_valid <= 1'b0;
        end else if (w_accept) begin
            r_ex_valid <= 1'b1;
            r_idex     <= w_idex_next;
        end else if (bus.ex_ready) begin
            r_ex_valid <= 1'b0;
        end
    end

    assign bus.ex_valid   = r_ex_valid;
    assign bus.ex_pc      = r_idex.pc;
    assign bus.ex_rs1_val = r_idex.rs1_val;
    assign bus.ex_rs2_val = r_idex.rs2_val;
    assign bus.ex_imm     = r_idex.imm;
    assign bus.ex_rd      = r_idex.rd;
    assign bus.ex_opcode  = r_idex.opcode;
    assign bus.ex_funct3  = r_idex.funct3;
    assign bus.ex_funct7  = r_idex.funct7;
    assign bus.ex_illegal = r_idex.illegal;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_decode_stage
//  Brief    : Directed self-checking bench for decode_stage with expected-
//             output scoreboard and a small register-file model
//  Revision : 1.0  initial release
// ============================================================================
module tb_decode_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        ill;
    } exp_t;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;
    exp_t sb[$];
    logic [31:0] regs [32] = '{default: '0};

    decode_stage_if bus ();

    decode_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: combinational read, write on the snooped writeback
    assign bus.rs1_data = regs[bus.readAddr1];
    assign bus.rs2_data = regs[bus.readAddr2];
    always @(posedge clk)
        if (bus.wb_writeEnable && bus.wb_writeAddr != 5'd0)
            regs[bus.wb_writeAddr] <= bus.wb_writeData;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] rs2,
                        input logic [31:0] imm, input logic [4:0] rd, input logic [6:0] op,
                        input logic [2:0] f3, input logic [6:0] f7, input logic ill);
        exp_t e;
        e = '{pc: pc, rs1: rs1, rs2: rs2, imm: imm, rd: rd, op: op, f3: f3, f7: f7, ill: ill};
        sb.push_back(e);
    endtask

    // Compare the ID/EX outputs against the oldest expected entry
    task automatic check_ex(input string tag, input bit do_pop);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
            return;
        end
        e = sb[0];
        chk({tag, "_valid"},   32'(bus.ex_valid),   32'd1);
        chk({tag, "_pc"},      bus.ex_pc,           e.pc);
        chk({tag, "_rs1"},     bus.ex_rs1_val,      e.rs1);
        chk({tag, "_rs2"},     bus.ex_rs2_val,      e.rs2);
        chk({tag, "_imm"},     bus.ex_imm,          e.imm);
        chk({tag, "_rd"},      32'(bus.ex_rd),      32'(e.rd));
        chk({tag, "_opcode"},  32'(bus.ex_opcode),  32'(e.op));
        chk({tag, "_funct3"},  32'(bus.ex_funct3),  32'(e.f3));
        chk({tag, "_funct7"},  32'(bus.ex_funct7),  32'(e.f7));
        chk({tag, "_illegal"}, 32'(bus.ex_illegal), 32'(e.ill));
        if (do_pop) void'(sb.pop_front());
    endtask

    task automatic present(input logic [31:0] instr, input logic [31:0] pc);
        bus.if_valid = 1'b1;
        bus.if_instr = instr;
        bus.if_pc    = pc;
    endtask

    task automatic wb(input logic en, input logic [4:0] a, input logic [31:0] d);
        bus.wb_writeEnable = en;
        bus.wb_writeAddr   = a;
        bus.wb_writeData   = d;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Linear directed sequence: drive just after posedge, check at negedge
    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset = 1'b1;
        bus.if_valid = 1'b0;
        bus.if_instr = 32'h0;
        bus.if_pc    = 32'h0;
        bus.flush    = 1'b0;
        bus.ex_ready = 1'b1;
        wb(1'b1, 5'd8, 32'hFFFF0000);          // preload x8 while in reset

        next_cycle();
        next_cycle();
        wb(1'b0, 5'd0, 32'h0);
        present(32'h0000_0000, 32'h0);
        bus.if_valid = 1'b0;
        @(negedge clk);
        chk("rst_ex_valid", 32'(bus.ex_valid), 32'd0);
        chk("rst_ex_pc",    bus.ex_pc,         32'd0);
        chk("rst_ex_imm",   bus.ex_imm,        32'd0);
        chk("rst_if_ready", 32'(bus.if_ready), 32'd0);
        chk("rst_busy",     dut.r_busy,        32'd0);

        // ADDI x4,x0,0xFFF
        next_cycle();
        reset = 1'b0;
        present(32'hFFF00213, 32'h100);
        push(32'h100, 32'h0, 32'h0, 32'hFFFFFFFF, 5'd4, 7'h13, 3'd0, 7'h7F, 1'b0);
        @(negedge clk);
        chk("addi_if_ready", 32'(bus.if_ready), 32'd1);

        // ADD x5,x4,x4 with no writeback: RAW stall
        next_cycle();
        present(32'h004202B3, 32'h104);
        @(negedge clk);
        check_ex("addi4", 1'b1);
        chk("busy_x4",       dut.r_busy, 32'h0000_0010);
        chk("raw_stall",     32'(bus.if_ready), 32'd0);

        // Writeback of x4 releases the stall in the same cycle via bypass
        next_cycle();
        wb(1'b1, 5'd4, 32'h0000FFFF);
        push(32'h104, 32'h0000FFFF, 32'h0000FFFF, 32'h0, 5'd5, 7'h33, 3'd0, 7'h00, 1'b0);
        @(negedge clk);
        chk("raw_drain_valid", 32'(bus.ex_valid), 32'd0);
        chk("bypass_ready",    32'(bus.if_ready), 32'd1);

        // SW x8,-4(x0)
        next_cycle();
        wb(1'b0, 5'd0, 32'h0);
        present(32'hFE802E23, 32'h108);
        push(32'h108, 32'h0, 32'hFFFF0000, 32'hFFFFFFFC, 5'd0, 7'h23, 3'd2, 7'h7F, 1'b0);
        @(negedge clk);
        check_ex("add5", 1'b1);
        chk("busy_after_add", dut.r_busy, 32'h0000_0020);

        // Backpressure: ex_ready low with SW held, ADDI x6,x0,5 offered
        next_cycle();
        bus.ex_ready = 1'b0;
        present(32'h00500313, 32'h10C);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_ex($sformatf("sw_hold%0d", i), 1'b0);
            chk($sformatf("hold_ready%0d", i), 32'(bus.if_ready), 32'd0);
            chk($sformatf("hold_busy%0d", i),  dut.r_busy, 32'h0000_0020);
            next_cycle();
        end
        bus.ex_ready = 1'b1;
        void'(sb.pop_front());                  // SW consumed at the coming edge
        push(32'h10C, 32'h0, 32'h0, 32'h5, 5'd6, 7'h13, 3'd0, 7'h00, 1'b0);
        @(negedge clk);
        chk("release_ready", 32'(bus.if_ready), 32'd1);

        // LUI x9,0x12345
        next_cycle();
        present(32'h123454B7, 32'h110);
        push(32'h110, 32'hFFFF0000, 32'h0, 32'h12345000, 5'd9, 7'h37, 3'd5, 7'h09, 1'b0);
        @(negedge clk);
        check_ex("addi6", 1'b1);
        chk("busy_x6", dut.r_busy, 32'h0000_0060);

        // Flush the held LUI
        next_cycle();
        bus.if_valid = 1'b0;
        bus.flush    = 1'b1;
        bus.ex_ready = 1'b0;
        @(negedge clk);
        check_ex("lui9", 1'b1);
        chk("busy_x9",     dut.r_busy, 32'h0000_0260);
        chk("flush_ready", 32'(bus.if_ready), 32'd0);

        // ADD x1,x9,x0 after the flush freed x9
        next_cycle();
        bus.flush    = 1'b0;
        bus.ex_ready = 1'b1;
        present(32'h000480B3, 32'h114);
        push(32'h114, 32'h0, 32'h0, 32'h0, 5'd1, 7'h33, 3'd0, 7'h00, 1'b0);
        @(negedge clk);
        chk("flush_valid",  32'(bus.ex_valid), 32'd0);
        chk("flush_busy",   dut.r_busy, 32'h0000_0060);
        chk("post_flush_ready", 32'(bus.if_ready), 32'd1);

        // Illegal opcode 0000000 with a nonzero rd field
        next_cycle();
        present(32'h00000380, 32'h118);
        push(32'h118, 32'h0, 32'h0, 32'h0, 5'd0, 7'h00, 3'd0, 7'h00, 1'b1);
        @(negedge clk);
        check_ex("add1", 1'b1);
        chk("busy_x1", dut.r_busy, 32'h0000_0062);

        next_cycle();
        bus.if_valid = 1'b0;
        @(negedge clk);
        check_ex("illegal", 1'b1);
        chk("illegal_busy", dut.r_busy, 32'h0000_0062);

        // ADDI x6 again: WAW on busy x6
        next_cycle();
        present(32'h00500313, 32'h11C);
        @(negedge clk);
        chk("waw_stall", 32'(bus.if_ready), 32'd0);

        next_cycle();
        wb(1'b1, 5'd6, 32'h00000077);
        push(32'h11C, 32'h0, 32'h0, 32'h5, 5'd6, 7'h13, 3'd0, 7'h00, 1'b0);
        @(negedge clk);
        chk("waw_release", 32'(bus.if_ready), 32'd1);

        // ADDI x10,x0,3 then reset mid-stream
        next_cycle();
        wb(1'b0, 5'd0, 32'h0);
        present(32'h00300513, 32'h120);
        push(32'h120, 32'h0, 32'h0, 32'h3, 5'd10, 7'h13, 3'd0, 7'h00, 1'b0);
        @(negedge clk);
        check_ex("addi6b", 1'b1);
        chk("waw_busy", dut.r_busy, 32'h0000_0062);

        next_cycle();
        bus.if_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check_ex("addi10", 1'b1);
        chk("busy_x10",         dut.r_busy, 32'h0000_0462);
        chk("reset_if_ready",   32'(bus.if_ready), 32'd0);

        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid",   32'(bus.ex_valid), 32'd0);
        chk("mid_rst_busy",    dut.r_busy, 32'd0);
        chk("mid_rst_pc",      bus.ex_pc, 32'd0);
        chk("mid_rst_rd",      32'(bus.ex_rd), 32'd0);
        chk("sb_drained",      32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
